vga_blank_write_arbiter: RTL
============================

// Module: vga_blank_write_arbiter
// PURPOSE
// - Shares the framebuffer write port between N_REQ drawing requesters; the port is read by the pixel path fed from sync_module.
// - Grants writes only inside a blanking window derived from sync_module's VGA_VS and valid, so no tearing occurs during active video.
// - Uses round-robin fairness, an optional per-frame write budget, and a per-frame write counter for debug.
// PARAMETERS
// - N_REQ    4   number of requesters (2..8)
// - P_WIDTH  11  coordinate width; equals `P_WIDTH in vga_params.v
// - DATA_W   3   pixel data width
// - V_ONLY   1   1: vertical-blank window only; 0: any cycle with valid==0 (horizontal blanking included)
// - BUDGET   0   max grants per frame window; 0 = unlimited
// PORTS
// - VGA_CLK    in   1              pixel clock (same clock as sync_module)
// - VGA_RST    in   1              asynchronous, active-high reset
// - VGA_VS     in   1              from sync_module; active low
// - valid      in   1              from sync_module; active-video flag
// - REQ        in   N_REQ          request per requester; held until granted
// - REQ_X      in   N_REQ*P_WIDTH  packed X, requester i at [i*P_WIDTH +: P_WIDTH]
// - REQ_Y      in   N_REQ*P_WIDTH  packed Y, same packing as REQ_X
// - REQ_DATA   in   N_REQ*DATA_W   packed pixel data
// - GNT        out  N_REQ          one-hot grant; write is accepted in the cycle GNT[i]=1
// - WR_EN      out  1              framebuffer write strobe; equals |GNT
// - WR_X/WR_Y  out  P_WIDTH        address of the granted requester
// - WR_DATA    out  DATA_W         data of the granted requester
// - FRAME_START out 1              1-cycle pulse on each VGA_VS falling edge
// - WR_COUNT   out  16             grants in the previous frame window; latched at FRAME_START
// BEHAVIOUR
// - Reset (async): win_st=CLOSED, rr_ptr=0, last_gnt=0, budget_cnt=0, cur_cnt=0, WR_COUNT=0, vs_d=1, FRAME_START=0.
// - While reset is asserted: GNT=0, WR_EN=0, WR_X/WR_Y/WR_DATA=0.
// - Window FSM (V_ONLY=1):
//   - CLOSED -> OPEN on the VGA_VS falling edge (vs_d & ~VGA_VS).
//   - OPEN -> CLOSED in the first cycle valid==1; valid==1 closes the window combinationally in that same cycle.
//   - Front porch before the next VS stays CLOSED. After reset, the window stays CLOSED until the first VS falling edge.
// - V_ONLY=0: window_open = ~valid, and the FSM is bypassed.
// - FRAME_START is registered: it asserts the cycle after the edge. On that cycle, WR_COUNT<=cur_cnt and cur_cnt<=0; budget_cnt<=0 at the same time.
// - Grant logic is combinational from the current REQ, window_open, rr_ptr and last_gnt. Latency is 0: no grant can land in an active-video cycle.
//   - Eligible[i] = REQ[i] & ~last_gnt[i] & window_open & (BUDGET==0 | budget_cnt<BUDGET).
//   - The winner is the first eligible index at or after rr_ptr, with wrap N_REQ-1 -> 0.
//   - A requester granted at cycle t is ineligible at t+1 (last_gnt mask). This prevents double writes while the requester drops REQ.
// - On a grant to index k:
//   - rr_ptr <= (k+1) mod N_REQ; last_gnt <= onehot(k).
//   - cur_cnt and budget_cnt increment, saturating at 16'hFFFF.
//   - With no grant, last_gnt <= 0 and rr_ptr holds.
// - WR_X/WR_Y/WR_DATA come from a mux of the winner's slice; they are 0 when WR_EN=0.
// - Simultaneous FRAME_START and grant: the counter reset wins for budget_cnt. The grant still counts into the new cur_cnt, which becomes 1.
// - The budget is exhausted when budget_cnt==BUDGET; all grants are then suppressed until the next FRAME_START.
// - REQ asserted with the window closed: no grant, and the request must stay held. No request is ever dropped.
// STRUCTURE
// - vga_params.v: P_WIDTH plus the H_/V_ timing macros; shared, no new defines.
// - Window FSM state encodings: localparams in this file.
// - One sub-module: rr_pick (N_REQ, combinational). Inputs are eligible and rr_ptr; outputs are the one-hot winner and its index.
// TESTING
// - Single requester: REQ[0] held across a VS fall -> GNT[0] on alternate cycles during vblank; GNT=0 while valid=1.
// - All 4 requesting in vblank, rr_ptr=0 -> grant order 0,1,2,3,0,...; no requester gets two grants in consecutive cycles.
// - BUDGET=5, 3 requesters requesting continuously -> exactly 5 grants per window; WR_COUNT=5 at the next FRAME_START.
// - Window close: REQ[2] held when valid rises -> GNT drops in that same cycle; the grant resumes after the next VS fall.
// - V_ONLY=0 -> grants during hblank cycles too; WR_X/WR_Y/WR_DATA match the requester's slice exactly.
// - Async VGA_RST mid-grant -> GNT, WR_EN and WR_COUNT go to 0 immediately; no grant before the first VS fall after release.

Source files
------------

// File: rtl/vga_blank_write_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_blank_write_arbiter_pkg: window FSM states and counter helpers | Rev 1.0
// ---------------------------------------------------------------------------
package vga_blank_write_arbiter_pkg;

  typedef enum logic [0:0] {
    WIN_CLOSED = 1'b0,
    WIN_OPEN   = 1'b1
  } win_state_t;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_blank_write_arbiter_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_blank_write_arbiter_rr_pick: first eligible index at/after rr_ptr | Rev 1.0
// ---------------------------------------------------------------------------
module vga_blank_write_arbiter_rr_pick
  import vga_blank_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         eligible,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         winner,
  output logic [$clog2(N_REQ)-1:0] win_idx,
  output logic                     found
);

  localparam int IW = $clog2(N_REQ);

  logic [IW:0] sum;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    sum     = '0;
    for (int off = 0; off < N_REQ; off++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(off);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (!found && eligible[sum[IW-1:0]]) begin
        found               = 1'b1;
        win_idx             = sum[IW-1:0];
        winner[sum[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_blank_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_blank_write_arbiter: round-robin framebuffer writes inside blanking | Rev 1.0
// ---------------------------------------------------------------------------
module vga_blank_write_arbiter
  import vga_blank_write_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int P_WIDTH = 11,
  parameter int DATA_W  = 3,
  parameter int V_ONLY  = 1,
  parameter int BUDGET  = 0
) (
  input  logic                      VGA_CLK,
  input  logic                      VGA_RST,
  input  logic                      VGA_VS,
  input  logic                      valid,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ*P_WIDTH-1:0]  REQ_X,
  input  logic [N_REQ*P_WIDTH-1:0]  REQ_Y,
  input  logic [N_REQ*DATA_W-1:0]   REQ_DATA,
  output logic [N_REQ-1:0]          GNT,
  output logic                      WR_EN,
  output logic [P_WIDTH-1:0]        WR_X,
  output logic [P_WIDTH-1:0]        WR_Y,
  output logic [DATA_W-1:0]         WR_DATA,
  output logic                      FRAME_START,
  output logic [CNT_W-1:0]          WR_COUNT
);

  localparam int               IW       = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] BUDGET_L = CNT_W'(BUDGET);

  win_state_t       win_st;
  logic             vs_d;
  logic [IW-1:0]    rr_ptr;
  logic [N_REQ-1:0] last_gnt;
  logic [CNT_W-1:0] budget_cnt;
  logic [CNT_W-1:0] cur_cnt;

  logic             vs_fall;
  logic             window_open;
  logic             budget_ok;
  logic [N_REQ-1:0] eligible;
  logic [IW-1:0]    win_idx;
  logic             found;

  assign vs_fall = vs_d & ~VGA_VS;

  // valid closes the vblank window in the very cycle it rises; reset forces everything idle
  assign window_open = ~VGA_RST & ~valid & ((V_ONLY == 0) || (win_st == WIN_OPEN));
  assign budget_ok   = (BUDGET == 0) || (budget_cnt < BUDGET_L);
  assign eligible    = REQ & ~last_gnt & {N_REQ{window_open & budget_ok}};

  vga_blank_write_arbiter_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .winner   (GNT),
    .win_idx  (win_idx),
    .found    (found)
  );

  assign WR_EN = found;

  always_comb begin
    WR_X    = '0;
    WR_Y    = '0;
    WR_DATA = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (GNT[i]) begin
        WR_X    = WR_X    | REQ_X[i*P_WIDTH +: P_WIDTH];
        WR_Y    = WR_Y    | REQ_Y[i*P_WIDTH +: P_WIDTH];
        WR_DATA = WR_DATA | REQ_DATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge VGA_CLK or posedge VGA_RST) begin
    if (VGA_RST) begin
      win_st      <= WIN_CLOSED;
      vs_d        <= 1'b1;
      FRAME_START <= 1'b0;
      rr_ptr      <= '0;
      last_gnt    <= '0;
      budget_cnt  <= '0;
      cur_cnt     <= '0;
      WR_COUNT    <= '0;
    end else begin
      vs_d        <= VGA_VS;
      FRAME_START <= vs_fall;

      case (win_st)
        WIN_CLOSED: if (vs_fall) win_st <= WIN_OPEN;
        WIN_OPEN:   if (valid)   win_st <= WIN_CLOSED;
        default:                 win_st <= WIN_CLOSED;
      endcase

      last_gnt <= GNT;
      if (found)
        rr_ptr <= (win_idx == IW'(N_REQ-1)) ? '0 : win_idx + 1'b1;

      // a grant landing on FRAME_START opens the new count but not the new budget
      if (FRAME_START) begin
        WR_COUNT   <= cur_cnt;
        cur_cnt    <= found ? CNT_W'(1) : '0;
        budget_cnt <= '0;
      end else if (found) begin
        cur_cnt    <= sat_inc(cur_cnt);
        budget_cnt <= sat_inc(budget_cnt);
      end
    end
  end

endmodule
`default_nettype wire
